fx_cfg_regfile: RTL and testbench



---
 rtl/fx_cfg_pkg.sv | 47 ++++
 rtl/fx_cfg_regfile_gain_ramp.sv | 43 ++++
 rtl/fx_cfg_regfile.sv | 137 +++++++++++++
 tb/tb_fx_cfg_regfile.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_cfg_pkg.sv
// Shared constants, reset defaults and FSM state type for the effects-chain
// configuration register file.
package fx_cfg_pkg;

   localparam int NUM_EFFECTS = 7;
   localparam int NUM_FUNCS   = 8;
   localparam int NUM_KNOBS   = 8;
   localparam int KSEL_W      = $clog2(NUM_KNOBS);
   localparam int FSEL_W      = $clog2(NUM_FUNCS);
   localparam int LIMIT_W     = 24;
   localparam int GAIN_W      = 8;
   localparam int FADE_STEP   = 1;
   localparam int ADDR_W      = 6;

   // Effect bit positions (debug_rec=0, swell=1, drive=2, chorus=3, delay=4, reverb=5, tremolo=6)
   localparam int FX_CHORUS  = 3;
   localparam int FX_DELAY   = 4;
   localparam int FX_TREMOLO = 6;

   localparam logic [ADDR_W-1:0] ADDR_EN     = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_LIMIT  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_KMAP0  = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_COMMIT = ADDR_W'((2 ** ADDR_W) - 1);

   localparam logic [GAIN_W-1:0] GAIN_FULL = '1;

   // Identity selection map: function f selects physical input f
   function automatic logic [NUM_FUNCS*KSEL_W-1:0] identity_knob_map();
      logic [NUM_FUNCS*KSEL_W-1:0] m;
      m = '0;
      for (int f = 0; f < NUM_FUNCS; f++) begin
         m[f*KSEL_W +: KSEL_W] = KSEL_W'(f);
      end
      return m;
   endfunction

   localparam logic [NUM_EFFECTS-1:0] DEFAULT_FX_EN =
      NUM_EFFECTS'((1 << FX_CHORUS) | (1 << FX_DELAY) | (1 << FX_TREMOLO));
   localparam logic [NUM_FUNCS*KSEL_W-1:0] DEFAULT_KNOB_MAP = identity_knob_map();
   localparam logic [LIMIT_W-1:0] DEFAULT_LIMIT = LIMIT_W'(4_000_000);

   typedef enum logic {
      ST_IDLE,
      ST_ARMED
   } cfg_state_e;

endpackage

// File: rtl/fx_cfg_regfile_gain_ramp.sv
// Single-effect saturating fade ramp: steps the mix gain toward full scale
// while enabled and toward zero while disabled, one step per sample tick.
module fx_gain_ramp
   import fx_cfg_pkg::*;
#(
   parameter bit RESET_EN = 1'b0
) (
   input  logic              clk,
   input  logic              srst_n,
   input  logic              en,
   input  logic              tick,
   output logic [GAIN_W-1:0] gain,
   output logic              active
);

   localparam logic [GAIN_W-1:0] GAIN_STEP = GAIN_W'(FADE_STEP);

   logic [GAIN_W-1:0] gain_next;

   // Saturating step toward the target implied by the current enable
   always_comb begin
      gain_next = gain;
      if (en) begin
         gain_next = (gain > GAIN_FULL - GAIN_STEP) ? GAIN_FULL : gain + GAIN_STEP;
      end else begin
         gain_next = (gain < GAIN_STEP) ? '0 : gain - GAIN_STEP;
      end
   end

   // Gain advances only on ticks; active tracks enable-or-audible a cycle later
   always_ff @(posedge clk) begin
      if (!srst_n) begin
         gain   <= RESET_EN ? GAIN_FULL : '0;
         active <= RESET_EN;
      end else begin
         if (tick) begin
            gain <= gain_next;
         end
         active <= en | (gain != '0);
      end
   end

endmodule

// File: rtl/fx_cfg_regfile.sv
// Runtime configuration register file: processor writes land in a shadow bank,
// a COMMIT arms a transfer that copies shadow to live on the next sample tick,
// and per-effect gain ramps fade effects in and out without clicks.
module fx_cfg_regfile
   import fx_cfg_pkg::*;
(
   input  logic                          clk_i,
   input  logic                          srst_n_i,
   input  logic                          sample_tick_i,
   input  logic                          wr_valid_i,
   output logic                          wr_ready_o,
   input  logic [ADDR_W-1:0]             wr_addr_i,
   input  logic [LIMIT_W-1:0]            wr_data_i,
   output logic                          wr_err_o,
   output logic [NUM_EFFECTS-1:0]        fx_en_o,
   output logic [NUM_EFFECTS-1:0]        fx_active_o,
   output logic [NUM_EFFECTS*GAIN_W-1:0] fx_gain_o,
   output logic [NUM_FUNCS*KSEL_W-1:0]   knob_sel_o,
   output logic [LIMIT_W-1:0]            limit_o
);

   cfg_state_e state_q, state_d;
   logic       apply;

   logic       wr_fire;
   logic       is_en, is_limit, is_kmap, is_commit, kmap_ok, wr_bad;
   logic [FSEL_W-1:0] kmap_idx;

   logic [NUM_EFFECTS-1:0]             shadow_en, live_en;
   logic [LIMIT_W-1:0]                 shadow_limit, live_limit;
   logic [NUM_FUNCS-1:0][KSEL_W-1:0]   shadow_kmap, live_kmap;
   logic                               err_q;

   assign wr_ready_o = (state_q == ST_IDLE);
   assign wr_fire    = wr_valid_i & wr_ready_o;

   // Address decode; a selector index is checked on the full data word so out-of-range values are rejected
   always_comb begin
      is_en     = (wr_addr_i == ADDR_EN);
      is_limit  = (wr_addr_i == ADDR_LIMIT);
      is_kmap   = (wr_addr_i >= ADDR_KMAP0) && (wr_addr_i < ADDR_KMAP0 + ADDR_W'(NUM_FUNCS));
      is_commit = (wr_addr_i == ADDR_COMMIT);
      kmap_ok   = (wr_data_i < LIMIT_W'(NUM_KNOBS));
      kmap_idx  = FSEL_W'(wr_addr_i - ADDR_KMAP0);
      wr_bad    = !(is_en || is_limit || (is_kmap && kmap_ok) || is_commit);
   end

   // Commit FSM next state: arm on COMMIT, apply on the first tick while armed
   always_comb begin
      state_d = state_q;
      apply   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (wr_fire && is_commit) begin
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (sample_tick_i) begin
               apply   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Commit FSM state register
   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Shadow bank takes accepted, valid data writes; reset discards unapplied writes
   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         shadow_en    <= DEFAULT_FX_EN;
         shadow_limit <= DEFAULT_LIMIT;
         shadow_kmap  <= DEFAULT_KNOB_MAP;
      end else if (wr_fire && !wr_bad) begin
         if (is_en) begin
            shadow_en <= wr_data_i[NUM_EFFECTS-1:0];
         end
         if (is_limit) begin
            shadow_limit <= wr_data_i;
         end
         if (is_kmap) begin
            shadow_kmap[kmap_idx] <= wr_data_i[KSEL_W-1:0];
         end
      end
   end

   // Live bank copies the whole shadow bank atomically on the applying tick
   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         live_en    <= DEFAULT_FX_EN;
         live_limit <= DEFAULT_LIMIT;
         live_kmap  <= DEFAULT_KNOB_MAP;
      end else if (apply) begin
         live_en    <= shadow_en;
         live_limit <= shadow_limit;
         live_kmap  <= shadow_kmap;
      end
   end

   // One-cycle error pulse for accepted writes that were ignored
   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         err_q <= 1'b0;
      end else begin
         err_q <= wr_fire && wr_bad;
      end
   end

   assign wr_err_o   = err_q;
   assign fx_en_o    = live_en;
   assign limit_o    = live_limit;
   assign knob_sel_o = live_kmap;

   // One fade ramp per effect, driven by the live enable as registered before each tick
   for (genvar e = 0; e < NUM_EFFECTS; e++) begin : g_ramp
      fx_gain_ramp #(
         .RESET_EN(DEFAULT_FX_EN[e])
      ) u_ramp (
         .clk    (clk_i),
         .srst_n (srst_n_i),
         .en     (live_en[e]),
         .tick   (sample_tick_i),
         .gain   (fx_gain_o[e*GAIN_W +: GAIN_W]),
         .active (fx_active_o[e])
      );
   end

endmodule

// File: tb/tb_fx_cfg_regfile.sv
// Directed self-checking bench for the configuration register file.
module tb_fx_cfg_regfile;

   logic        clk_i = 1'b0;
   logic        srst_n_i = 1'b0;
   logic        sample_tick_i = 1'b0;
   logic        wr_valid_i = 1'b0;
   logic        wr_ready_o;
   logic [5:0]  wr_addr_i = '0;
   logic [23:0] wr_data_i = '0;
   logic        wr_err_o;
   logic [6:0]  fx_en_o;
   logic [6:0]  fx_active_o;
   logic [55:0] fx_gain_o;
   logic [23:0] knob_sel_o;
   logic [23:0] limit_o;

   int tests_run = 0;
   int tests_failed = 0;

   localparam logic [6:0]  EXP_DEF_EN    = 7'b1011000;
   localparam logic [23:0] EXP_IDENT_MAP = 24'hFAC688;
   localparam logic [55:0] EXP_DEF_GAIN  = 56'hFF_00_FF_FF_00_00_00;

   fx_cfg_regfile dut (
      .clk_i         (clk_i),
      .srst_n_i      (srst_n_i),
      .sample_tick_i (sample_tick_i),
      .wr_valid_i    (wr_valid_i),
      .wr_ready_o    (wr_ready_o),
      .wr_addr_i     (wr_addr_i),
      .wr_data_i     (wr_data_i),
      .wr_err_o      (wr_err_o),
      .fx_en_o       (fx_en_o),
      .fx_active_o   (fx_active_o),
      .fx_gain_o     (fx_gain_o),
      .knob_sel_o    (knob_sel_o),
      .limit_o       (limit_o)
   );

   always #5 clk_i = ~clk_i;

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // One sample tick followed by a quiet cycle
   task automatic pulse_tick();
      sample_tick_i = 1'b1;
      step();
      sample_tick_i = 1'b0;
      step();
   endtask

   // Hold a write valid until accepted; returns wr_err_o seen the cycle after acceptance
   task automatic do_write(input logic [5:0] addr, input logic [23:0] data, output logic err);
      int budget;
      budget = 0;
      wr_valid_i = 1'b1;
      wr_addr_i  = addr;
      wr_data_i  = data;
      while (wr_ready_o !== 1'b1 && budget < 50) begin
         step();
         budget++;
      end
      if (budget >= 50) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL write_timeout: addr %0d never accepted", addr);
      end
      step();
      wr_valid_i = 1'b0;
      err = wr_err_o;
   endtask

   task automatic test_reset();
      srst_n_i = 1'b0;
      repeat (3) step();
      srst_n_i = 1'b1;
      step();
      tests_run++;
      if (fx_en_o !== EXP_DEF_EN) begin
         tests_failed++;
         $display("[TB] FAIL reset_en: got %b expected %b", fx_en_o, EXP_DEF_EN);
      end
      tests_run++;
      if (knob_sel_o !== EXP_IDENT_MAP) begin
         tests_failed++;
         $display("[TB] FAIL reset_kmap: got %h expected %h", knob_sel_o, EXP_IDENT_MAP);
      end
      tests_run++;
      if (limit_o !== 24'd4_000_000) begin
         tests_failed++;
         $display("[TB] FAIL reset_limit: got %0d expected 4000000", limit_o);
      end
      tests_run++;
      if (fx_gain_o !== EXP_DEF_GAIN) begin
         tests_failed++;
         $display("[TB] FAIL reset_gain: got %h expected %h", fx_gain_o, EXP_DEF_GAIN);
      end
      tests_run++;
      if (fx_active_o !== EXP_DEF_EN) begin
         tests_failed++;
         $display("[TB] FAIL reset_active: got %b expected %b", fx_active_o, EXP_DEF_EN);
      end
      tests_run++;
      if (wr_ready_o !== 1'b1 || wr_err_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reset_handshake: ready %b err %b expected 1 0", wr_ready_o, wr_err_o);
      end
   endtask

   task automatic test_shadow_hold();
      logic err;
      do_write(6'd1, 24'd1_000_000, err);
      tests_run++;
      if (err !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL limit_write_err: got %b expected 0", err);
      end
      do_write(6'd0, 24'd0, err);
      repeat (5) pulse_tick();
      tests_run++;
      if (limit_o !== 24'd4_000_000 || fx_en_o !== EXP_DEF_EN) begin
         tests_failed++;
         $display("[TB] FAIL shadow_hold: limit %0d en %b expected 4000000 %b", limit_o, fx_en_o, EXP_DEF_EN);
      end
      tests_run++;
      if (fx_gain_o !== EXP_DEF_GAIN) begin
         tests_failed++;
         $display("[TB] FAIL shadow_hold_gain: got %h expected %h", fx_gain_o, EXP_DEF_GAIN);
      end
   endtask

   task automatic test_commit_stall();
      logic err;
      do_write(6'd63, 24'd0, err);
      tests_run++;
      if (wr_ready_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL armed_ready: got %b expected 0", wr_ready_o);
      end
      wr_valid_i = 1'b1;
      wr_addr_i  = 6'd2;
      wr_data_i  = 24'd5;
      step();
      step();
      tests_run++;
      if (wr_ready_o !== 1'b0 || limit_o !== 24'd4_000_000) begin
         tests_failed++;
         $display("[TB] FAIL armed_wait: ready %b limit %0d expected 0 4000000", wr_ready_o, limit_o);
      end
      sample_tick_i = 1'b1;
      step();
      sample_tick_i = 1'b0;
      tests_run++;
      if (limit_o !== 24'd1_000_000 || fx_en_o !== 7'b0) begin
         tests_failed++;
         $display("[TB] FAIL commit_apply: limit %0d en %b expected 1000000 0000000", limit_o, fx_en_o);
      end
      tests_run++;
      if (wr_ready_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL commit_ready: got %b expected 1", wr_ready_o);
      end
      tests_run++;
      if (fx_gain_o !== EXP_DEF_GAIN) begin
         tests_failed++;
         $display("[TB] FAIL commit_tick_gain: got %h expected %h", fx_gain_o, EXP_DEF_GAIN);
      end
      step();
      wr_valid_i = 1'b0;
      tests_run++;
      if (wr_err_o !== 1'b0 || knob_sel_o !== EXP_IDENT_MAP) begin
         tests_failed++;
         $display("[TB] FAIL stalled_write: err %b kmap %h expected 0 %h", wr_err_o, knob_sel_o, EXP_IDENT_MAP);
      end
   endtask

   task automatic test_fade_out();
      repeat (254) pulse_tick();
      tests_run++;
      if (fx_gain_o[3*8 +: 8] !== 8'd1 || fx_active_o[3] !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL fade_254: gain %0d active %b expected 1 1", fx_gain_o[3*8 +: 8], fx_active_o[3]);
      end
      sample_tick_i = 1'b1;
      step();
      sample_tick_i = 1'b0;
      tests_run++;
      if (fx_gain_o[3*8 +: 8] !== 8'd0 || fx_active_o[3] !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL fade_255: gain %0d active %b expected 0 1", fx_gain_o[3*8 +: 8], fx_active_o[3]);
      end
      step();
      tests_run++;
      if (fx_active_o !== 7'b0) begin
         tests_failed++;
         $display("[TB] FAIL fade_active_fall: got %b expected 0000000", fx_active_o);
      end
      pulse_tick();
      tests_run++;
      if (fx_gain_o !== 56'h0) begin
         tests_failed++;
         $display("[TB] FAIL fade_floor: got %h expected 0", fx_gain_o);
      end
   endtask

   task automatic test_bad_writes();
      logic err;
      do_write(6'd2, 24'd9, err);
      tests_run++;
      if (err !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL kmap_range_err: got %b expected 1", err);
      end
      step();
      tests_run++;
      if (wr_err_o !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL err_pulse_width: got %b expected 0", wr_err_o);
      end
      do_write(6'd40, 24'd123, err);
      tests_run++;
      if (err !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL bad_addr_err: got %b expected 1", err);
      end
      do_write(6'd0, 24'hFFFF81, err);
      tests_run++;
      if (err !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL wide_data_err: got %b expected 0", err);
      end
      do_write(6'd63, 24'd0, err);
      sample_tick_i = 1'b1;
      step();
      sample_tick_i = 1'b0;
      tests_run++;
      if (knob_sel_o !== 24'hFAC68D) begin
         tests_failed++;
         $display("[TB] FAIL bad_write_kmap: got %h expected fac68d", knob_sel_o);
      end
      tests_run++;
      if (fx_en_o !== 7'b0000001 || limit_o !== 24'd1_000_000) begin
         tests_failed++;
         $display("[TB] FAIL bad_write_state: en %b limit %0d expected 0000001 1000000", fx_en_o, limit_o);
      end
   endtask

   task automatic test_reset_armed();
      logic err;
      do_write(6'd1, 24'd777, err);
      do_write(6'd0, 24'h7F, err);
      do_write(6'd63, 24'd0, err);
      srst_n_i = 1'b0;
      step();
      srst_n_i = 1'b1;
      tests_run++;
      if (wr_ready_o !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL armed_reset_ready: got %b expected 1", wr_ready_o);
      end
      tests_run++;
      if (fx_en_o !== EXP_DEF_EN || limit_o !== 24'd4_000_000 || knob_sel_o !== EXP_IDENT_MAP) begin
         tests_failed++;
         $display("[TB] FAIL armed_reset_defaults: en %b limit %0d kmap %h", fx_en_o, limit_o, knob_sel_o);
      end
      tests_run++;
      if (fx_gain_o !== EXP_DEF_GAIN) begin
         tests_failed++;
         $display("[TB] FAIL armed_reset_gain: got %h expected %h", fx_gain_o, EXP_DEF_GAIN);
      end
      pulse_tick();
      pulse_tick();
      tests_run++;
      if (fx_en_o !== EXP_DEF_EN || limit_o !== 24'd4_000_000) begin
         tests_failed++;
         $display("[TB] FAIL armed_reset_no_apply: en %b limit %0d", fx_en_o, limit_o);
      end
      do_write(6'd63, 24'd0, err);
      sample_tick_i = 1'b1;
      step();
      sample_tick_i = 1'b0;
      tests_run++;
      if (fx_en_o !== EXP_DEF_EN || limit_o !== 24'd4_000_000 || knob_sel_o !== EXP_IDENT_MAP) begin
         tests_failed++;
         $display("[TB] FAIL armed_reset_shadow: en %b limit %0d kmap %h", fx_en_o, limit_o, knob_sel_o);
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_shadow_hold();
      test_commit_stall();
      test_fade_out();
      test_bad_writes();
      test_reset_armed();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
